// File: rtl/id_exe_reg_pkg.sv
// Shared encodings and field layout for the ID/EXE pipeline boundary.
package id_exe_reg_pkg;

  localparam int CTRL_W = 9;
  localparam int IMM_W  = 37;
  localparam int DEST_W = 4;
  localparam int COND_W = 4;

  // ctrl bit positions: {wb_en, mem_r, mem_w, b, s, exe_cmd[3:0]}
  localparam int CTRL_WB_EN   = 8;
  localparam int CTRL_MEM_R   = 7;
  localparam int CTRL_MEM_W   = 6;
  localparam int CTRL_B       = 5;
  localparam int CTRL_S       = 4;
  localparam int CTRL_EXE_LSB = 0;

  // imm_fields layout: {imm(1), shift_operand(12), signed_imm_24(24)}
  localparam int IMM_BIT       = 36;
  localparam int IMM_SHIFT_LSB = 24;
  localparam int IMM_SIMM_LSB  = 0;

  typedef enum logic [3:0] {
    EXE_NOP = 4'b0000,
    EXE_MOV = 4'b0001,
    EXE_ADD = 4'b0010,
    EXE_ADC = 4'b0011,
    EXE_SUB = 4'b0100,
    EXE_SBC = 4'b0101,
    EXE_AND = 4'b0110,
    EXE_ORR = 4'b0111,
    EXE_EOR = 4'b1000,
    EXE_MVN = 4'b1001
  } exe_cmd_e;

  typedef enum logic [3:0] {
    COND_EQ = 4'h0, COND_NE = 4'h1, COND_CS = 4'h2, COND_CC = 4'h3,
    COND_MI = 4'h4, COND_PL = 4'h5, COND_VS = 4'h6, COND_VC = 4'h7,
    COND_HI = 4'h8, COND_LS = 4'h9, COND_GE = 4'hA, COND_LT = 4'hB,
    COND_GT = 4'hC, COND_LE = 4'hD, COND_AL = 4'hE
  } cond_e;

  function automatic exe_cmd_e ctrl_exe_cmd(input logic [CTRL_W-1:0] ctrl);
    return exe_cmd_e'(ctrl[CTRL_EXE_LSB +: 4]);
  endfunction

endpackage

// File: rtl/id_exe_reg_if.sv
// One pipeline-stage instruction bundle; instantiated once on each side of the register.
interface id_exe_reg_if
  import id_exe_reg_pkg::*;
#(
  parameter int WORD_W = 32
);
  logic                valid;
  logic [WORD_W-1:0]   pc;
  logic [2*WORD_W-1:0] ops;
  logic [IMM_W-1:0]    imm_fields;
  logic [DEST_W-1:0]   dest;
  logic [CTRL_W-1:0]   ctrl;
  logic [COND_W-1:0]   cond;

  modport master (output valid, pc, ops, imm_fields, dest, ctrl, cond);
  modport slave  (input  valid, pc, ops, imm_fields, dest, ctrl, cond);
endinterface

// File: rtl/id_exe_reg_pipe_reg.sv
// Generic register slice: async reset, synchronous clear (wins over enable), load enable.
module id_exe_reg_pipe_reg #(
  parameter int W = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_clr,
  input  logic         i_en,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);
  logic [W-1:0] r_q;

  // NOTE: sequential state uses <= so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)       r_q <= '0;
    else if (i_clr) r_q <= '0;
    else if (i_en)  r_q <= i_d;
  end

  assign o_q = r_q;
endmodule

// File: rtl/id_exe_reg.sv
// ID/EXE pipeline register with flush/freeze control and a saturating bubble counter.
module id_exe_reg
  import id_exe_reg_pkg::*;
#(
  parameter int WORD_W = 32,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_flush,
  input  logic              i_freeze,
  id_exe_reg_if.slave       i_id,
  id_exe_reg_if.master      o_exe,
  output logic [CNT_W-1:0]  o_bubble_cnt
);
  logic             w_bubble;
  logic             w_en;
  logic [CNT_W-1:0] r_bubble_cnt;

  // A bubble is either a squash (beats freeze) or an unfrozen load of an empty slot.
  assign w_bubble = i_flush | (~i_freeze & ~i_id.valid);
  assign w_en     = ~i_freeze;

  id_exe_reg_pipe_reg #(.W(1)) u_valid (
    .clk(clk), .rst(rst), .i_clr(w_bubble), .i_en(w_en),
    .i_d(i_id.valid), .o_q(o_exe.valid));

  id_exe_reg_pipe_reg #(.W(WORD_W)) u_pc (
    .clk(clk), .rst(rst), .i_clr(w_bubble), .i_en(w_en),
    .i_d(i_id.pc), .o_q(o_exe.pc));

  id_exe_reg_pipe_reg #(.W(2*WORD_W)) u_ops (
    .clk(clk), .rst(rst), .i_clr(w_bubble), .i_en(w_en),
    .i_d(i_id.ops), .o_q(o_exe.ops));

  id_exe_reg_pipe_reg #(.W(IMM_W)) u_imm (
    .clk(clk), .rst(rst), .i_clr(w_bubble), .i_en(w_en),
    .i_d(i_id.imm_fields), .o_q(o_exe.imm_fields));

  id_exe_reg_pipe_reg #(.W(DEST_W)) u_dest (
    .clk(clk), .rst(rst), .i_clr(w_bubble), .i_en(w_en),
    .i_d(i_id.dest), .o_q(o_exe.dest));

  id_exe_reg_pipe_reg #(.W(CTRL_W)) u_ctrl (
    .clk(clk), .rst(rst), .i_clr(w_bubble), .i_en(w_en),
    .i_d(i_id.ctrl), .o_q(o_exe.ctrl));

  id_exe_reg_pipe_reg #(.W(COND_W)) u_cond (
    .clk(clk), .rst(rst), .i_clr(w_bubble), .i_en(w_en),
    .i_d(i_id.cond), .o_q(o_exe.cond));

  // Only rst clears the count; it sticks at all-ones once saturated.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      r_bubble_cnt <= '0;
    else if (w_bubble && (r_bubble_cnt != '1))
      r_bubble_cnt <= r_bubble_cnt + 1'b1;
  end

  assign o_bubble_cnt = r_bubble_cnt;
endmodule

// File: tb/tb_id_exe_reg.sv
// Directed bench for id_exe_reg: vector table plus reset and saturation sequences.
module tb_id_exe_reg;
  import id_exe_reg_pkg::*;

  localparam int WORD_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [WORD_W-1:0] OPS_MASK = 32'hA5A5_A5A5;

  logic             clk = 1'b0;
  logic             rst;
  logic             flush;
  logic             freeze;
  logic [CNT_W-1:0] bubble_cnt;
  int               checks = 0;
  int               errors = 0;

  id_exe_reg_if #(.WORD_W(WORD_W)) id_if ();
  id_exe_reg_if #(.WORD_W(WORD_W)) exe_if ();

  id_exe_reg #(.WORD_W(WORD_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .i_flush(flush), .i_freeze(freeze),
    .i_id(id_if), .o_exe(exe_if), .o_bubble_cnt(bubble_cnt));

  always #5 clk = ~clk;

  typedef struct {
    logic        fl, fz, v;
    logic [31:0] pc;
    logic [3:0]  dest;
    logic [8:0]  ctrl;
    logic [3:0]  cond;
    logic        ev;
    logic [31:0] epc;
    logic [3:0]  edest;
    logic [8:0]  ectrl;
    logic [3:0]  econd;
    logic [15:0] ecnt;
  } vec_t;

  function automatic vec_t mk(input logic fl, fz, v, input logic [31:0] pc,
                              input logic [3:0] dest, input logic [8:0] ctrl,
                              input logic [3:0] cond, input logic ev,
                              input logic [31:0] epc, input logic [3:0] edest,
                              input logic [8:0] ectrl, input logic [3:0] econd,
                              input logic [15:0] ecnt);
    vec_t t;
    t.fl = fl; t.fz = fz; t.v = v; t.pc = pc; t.dest = dest; t.ctrl = ctrl;
    t.cond = cond; t.ev = ev; t.epc = epc; t.edest = edest; t.ectrl = ectrl;
    t.econd = econd; t.ecnt = ecnt;
    return t;
  endfunction

  function automatic logic [63:0] ops_of(input logic [31:0] pc);
    return {pc, pc ^ OPS_MASK};
  endfunction

  function automatic logic [36:0] imm_of(input logic [31:0] pc);
    return {pc[2], pc[13:2], pc[31:8]};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input logic fl, fz, v, input logic [31:0] pc,
                       input logic [3:0] dest, input logic [8:0] ctrl, input logic [3:0] cond);
    flush = fl; freeze = fz;
    id_if.valid = v; id_if.pc = pc; id_if.ops = ops_of(pc);
    id_if.imm_fields = imm_of(pc); id_if.dest = dest; id_if.ctrl = ctrl; id_if.cond = cond;
    @(posedge clk);
    #1;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".valid"}, 64'(exe_if.valid), 64'd0);
    check({tag, ".pc"},    64'(exe_if.pc), 64'd0);
    check({tag, ".ops"},   exe_if.ops, 64'd0);
    check({tag, ".imm"},   64'(exe_if.imm_fields), 64'd0);
    check({tag, ".ctrl"},  64'(exe_if.ctrl), 64'd0);
    check({tag, ".cond"},  64'(exe_if.cond), 64'd0);
    check({tag, ".cnt"},   64'(bubble_cnt), 64'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[15];
    vecs[0]  = mk(0,0,1,32'h40,4'h3,9'h1A4,4'hE,        1,32'h40,4'h3,9'h1A4,4'hE,16'd0);
    vecs[1]  = mk(0,0,1,32'h44,4'hF,9'h1FF,4'h0,        1,32'h44,4'hF,9'h1FF,4'h0,16'd0);
    vecs[2]  = mk(0,1,1,32'h99,4'h1,9'h001,4'h1,        1,32'h44,4'hF,9'h1FF,4'h0,16'd0);
    vecs[3]  = mk(0,1,0,32'h98,4'h2,9'h002,4'h2,        1,32'h44,4'hF,9'h1FF,4'h0,16'd0);
    vecs[4]  = mk(0,1,1,32'hAA,4'h7,9'h0F0,4'h7,        1,32'h44,4'hF,9'h1FF,4'h0,16'd0);
    vecs[5]  = mk(1,1,1,32'h50,4'h4,9'h1A4,4'hE,        0,32'h0,4'h0,9'h0,4'h0,16'd1);
    vecs[6]  = mk(0,0,0,32'h60,4'h6,9'h1FF,4'h3,        0,32'h0,4'h0,9'h0,4'h0,16'd2);
    vecs[7]  = mk(0,1,1,32'h70,4'h8,9'h1A4,4'hE,        0,32'h0,4'h0,9'h0,4'h0,16'd2);
    vecs[8]  = mk(1,0,1,32'h80,4'h9,9'h1A4,4'hE,        0,32'h0,4'h0,9'h0,4'h0,16'd3);
    vecs[9]  = mk(0,0,1,32'hDEADBEEC,4'hA,9'h155,4'hA,  1,32'hDEADBEEC,4'hA,9'h155,4'hA,16'd3);
    vecs[10] = mk(0,0,1,32'hFFFFFFFC,4'hC,9'h0AA,4'h5,  1,32'hFFFFFFFC,4'hC,9'h0AA,4'h5,16'd3);
    vecs[11] = mk(1,0,1,32'h88,4'h1,9'h1A4,4'hE,        0,32'h0,4'h0,9'h0,4'h0,16'd4);
    vecs[12] = mk(0,0,1,32'h100,4'h2,9'h1A4,4'hE,       1,32'h100,4'h2,9'h1A4,4'hE,16'd4);
    vecs[13] = mk(0,0,0,32'h104,4'h3,9'h1A4,4'hE,       0,32'h0,4'h0,9'h0,4'h0,16'd5);
    vecs[14] = mk(0,0,1,32'h200,4'h5,9'h101,4'h0,       1,32'h200,4'h5,9'h101,4'h0,16'd5);

    rst = 1'b1; flush = 1'b0; freeze = 1'b0;
    id_if.valid = 1'b0; id_if.pc = '0; id_if.ops = '0; id_if.imm_fields = '0;
    id_if.dest = '0; id_if.ctrl = '0; id_if.cond = '0;
    @(posedge clk);
    #1;
    check_zero("reset");
    rst = 1'b0;

    for (int i = 0; i < 15; i++) begin
      drive(vecs[i].fl, vecs[i].fz, vecs[i].v, vecs[i].pc, vecs[i].dest, vecs[i].ctrl, vecs[i].cond);
      check($sformatf("v%0d.valid", i), 64'(exe_if.valid), 64'(vecs[i].ev));
      check($sformatf("v%0d.pc", i),    64'(exe_if.pc), 64'(vecs[i].epc));
      check($sformatf("v%0d.ops", i),   exe_if.ops, vecs[i].ev ? ops_of(vecs[i].epc) : 64'd0);
      check($sformatf("v%0d.imm", i),   64'(exe_if.imm_fields),
            vecs[i].ev ? 64'(imm_of(vecs[i].epc)) : 64'd0);
      check($sformatf("v%0d.dest", i),  64'(exe_if.dest), 64'(vecs[i].edest));
      check($sformatf("v%0d.ctrl", i),  64'(exe_if.ctrl), 64'(vecs[i].ectrl));
      check($sformatf("v%0d.cond", i),  64'(exe_if.cond), 64'(vecs[i].econd));
      check($sformatf("v%0d.cnt", i),   64'(bubble_cnt), 64'(vecs[i].ecnt));
    end

    // Async reset between edges while valid_out=1 and bubble_cnt=5.
    #2 rst = 1'b1;
    #1 check_zero("async_rst");
    #1 rst = 1'b0;
    drive(0,0,1,32'h300,4'h6,9'h1A4,4'hE);
    check("post_rst.valid", 64'(exe_if.valid), 64'd1);
    check("post_rst.pc",    64'(exe_if.pc), 64'h300);
    check("post_rst.ctrl",  64'(exe_if.ctrl), 64'h1A4);
    check("post_rst.cnt",   64'(bubble_cnt), 64'd0);

    // Reset held across an edge with flush and freeze both asserted.
    rst = 1'b1;
    drive(1,1,1,32'h310,4'h1,9'h1FF,4'h1);
    check_zero("rst_over_flush");
    rst = 1'b0;
    drive(0,1,1,32'h320,4'h2,9'h1FF,4'h2);
    check("rst_then_freeze.valid", 64'(exe_if.valid), 64'd0);
    check("rst_then_freeze.cnt",   64'(bubble_cnt), 64'd0);
    drive(0,0,1,32'h400,4'h4,9'h0C3,4'hB);
    check("rst_then_load.valid", 64'(exe_if.valid), 64'd1);
    check("rst_then_load.pc",    64'(exe_if.pc), 64'h400);
    check("rst_then_load.cond",  64'(exe_if.cond), 64'hB);

    // Saturation: count up to 0xFFFE, then three more bubble edges.
    for (int k = 0; k < 65534; k++) drive(1,0,1,32'h500,4'h5,9'h1A4,4'hE);
    check("sat.pre", 64'(bubble_cnt), 64'hFFFE);
    for (int k = 0; k < 3; k++) begin
      drive(k[0], 1'b0, 1'b0, 32'h600, 4'h6, 9'h1A4, 4'hE);
      check($sformatf("sat%0d.cnt", k),   64'(bubble_cnt), 64'hFFFF);
      check($sformatf("sat%0d.valid", k), 64'(exe_if.valid), 64'd0);
      check($sformatf("sat%0d.ctrl", k),  64'(exe_if.ctrl), 64'd0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/id_exe_reg.md
ID_EXE_REG -- requirements
Module: id_exe_reg

Interface
REQ-001 Parameter: WORD_W, 32, datapath word width (PC and operand values).
REQ-002 Parameter: CNT_W, 16, width of bubble counter.
REQ-003 clk  in  1  single clock; all state updates on rising edge.
REQ-004 rst  in  1  asynchronous, active-high reset.
REQ-005 flush  in  1  branch-taken squash of the instruction entering EXE.
REQ-006 freeze  in  1  hazard stall; hold current contents.
REQ-007 valid_in  in  1  ID stage presents a real instruction.
REQ-008 pc_in  in  WORD_W  PC of ID instruction.
REQ-009 ops_in  in  2*WORD_W  {val_rn, val_rm}.
REQ-010 imm_fields_in  in  37  {imm(1), shift_operand(12), signed_imm_24(24)}.
REQ-011 dest_in  in  4  destination register index.
REQ-012 ctrl_in  in  9  {wb_en, mem_r, mem_w, b, s, exe_cmd[3:0]}.
REQ-013 cond_in  in  4  instruction condition field, consumed in EXE by condition check.
REQ-014 valid_out, pc_out, ops_out, imm_fields_out, dest_out, ctrl_out, cond_out  out  widths as inputs  registered EXE-stage copies.
REQ-015 bubble_cnt  out  CNT_W  count of bubbles inserted into EXE.

Function
REQ-016 Block SHALL be a one-cycle pipeline register: inputs sampled at edge N appear on outputs after edge N, unchanged until next update.
REQ-017 Per-edge priority SHALL be rst > flush > freeze > load.
REQ-018 flush=1 SHALL load a bubble: valid_out=0, ctrl_out=0, all other data outputs 0, regardless of freeze.
REQ-019 freeze=1 with flush=0 SHALL hold every output, including bubble_cnt.
REQ-020 Load with valid_in=1 SHALL copy all inputs to outputs unmodified.
REQ-021 Load with valid_in=0 SHALL behave as flush (bubble, ctrl_out=0).
REQ-022 ctrl_out SHALL be 0 whenever valid_out=0, so no write-back, memory access, branch or status update can originate from a bubble.
REQ-023 cond_out SHALL be 0 in a bubble; downstream gating relies on ctrl_out=0, not on cond_out.
REQ-024 bubble_cnt SHALL increment by 1 on each edge that loads a bubble (flush, or load with valid_in=0), and SHALL saturate at all-ones.
REQ-025 bubble_cnt SHALL be cleared only by rst.
REQ-026 Outputs SHALL be driven purely from registers; no combinational input-to-output path.

Reset
REQ-027 rst assertion SHALL immediately, without clock, force all outputs to 0 (valid_out=0, bubble_cnt=0).
REQ-028 rst asserted mid-stall or mid-flush SHALL override both; first edge after deassertion SHALL follow REQ-017 normally.

Structure
REQ-029 Shared package SHALL hold: ctrl bit positions, exe_cmd encodings, 4-bit condition-code constants (EQ..AL), imm_fields bit offsets.
REQ-030 Natural sub-module: pipe_reg (parameterised width, async rst, synchronous clr, enable), one instance per field group; counter logic stays in id_exe_reg.

Verification
REQ-031 Load: valid_in=1, pc_in=0x40, ctrl_in=0x1A4, cond_in=0xE -> next edge pc_out=0x40, ctrl_out=0x1A4, cond_out=0xE, valid_out=1, bubble_cnt unchanged.
REQ-032 Freeze: freeze=1 for 3 edges with changing inputs -> outputs and bubble_cnt identical to values before stall.
REQ-033 Flush+freeze same edge: flush=1, freeze=1, valid_in=1 -> valid_out=0, ctrl_out=0, bubble_cnt +1.
REQ-034 Saturation: preload bubble_cnt to 0xFFFE, 3 bubble edges -> 0xFFFF, 0xFFFF, 0xFFFF.
REQ-035 Async reset: rst pulse between edges while valid_out=1, bubble_cnt=5 -> all outputs 0 before next edge; next load edge with valid_in=1 resumes REQ-020.
